// File: rtl/fp_sign_sched_pkg.sv
// Shared encodings and constants for the fp_sign scheduler slice:
// sign-injection op codes, formats and the canonical NaN-box values.
package fp_sign_sched_pkg;

  typedef enum logic [1:0] {
    FP_OP_SGNJ  = 2'b00,
    FP_OP_SGNJN = 2'b01,
    FP_OP_SGNJX = 2'b10,
    FP_OP_RSVD  = 2'b11
  } fp_op_e;

  typedef enum logic {
    FP_FMT_S = 1'b0,
    FP_FMT_D = 1'b1
  } fp_fmt_e;

  localparam logic [31:0] CANON_NAN_S = 32'h7FC0_0000;
  localparam logic [31:0] NAN_BOX_HI  = 32'hFFFF_FFFF;

  // A single-precision value is only legal when its upper half is all ones;
  // anything else reads as the canonical quiet NaN, still properly boxed.
  function automatic logic [63:0] nan_box_canon(input logic [63:0] x, input logic fmt);
    if ((fmt == FP_FMT_S) && (x[63:32] != NAN_BOX_HI)) begin
      return {NAN_BOX_HI, CANON_NAN_S};
    end
    return x;
  endfunction

endpackage

// File: rtl/fp_sign.sv
// Single-cycle FSGNJ/FSGNJN/FSGNJX datapath. Everything except the sign bit
// of the selected format comes from op_a; the reserved op keeps op_a's sign.
module fp_sign
  import fp_sign_sched_pkg::*;
#(
  parameter int FLEN = 64
) (
  input  logic [FLEN-1:0] op_a,
  input  logic [FLEN-1:0] op_b,
  input  logic [1:0]      op,
  input  logic            fmt,
  output logic [FLEN-1:0] result
);

  logic sign_a;
  logic sign_b;
  logic sign_new;
  logic unused_b;

  // op_b contributes only its sign bit
  assign unused_b = ^op_b;

  always_comb begin
    sign_a   = (fmt == FP_FMT_D) ? op_a[FLEN-1] : op_a[31];
    sign_b   = (fmt == FP_FMT_D) ? op_b[FLEN-1] : op_b[31];
    sign_new = sign_a;
    case (fp_op_e'(op))
      FP_OP_SGNJ:  sign_new = sign_b;
      FP_OP_SGNJN: sign_new = ~sign_b;
      FP_OP_SGNJX: sign_new = sign_a ^ sign_b;
      default:     sign_new = sign_a;
    endcase

    result = op_a;
    if (fmt == FP_FMT_D) begin
      result[FLEN-1] = sign_new;
    end else begin
      result[31] = sign_new;
    end
  end

endmodule

// File: rtl/fp_sign_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo NUM_REQ. Purely combinational.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W:0] cand;

  // Scan NUM_REQ candidates starting at ptr; the extra bit in cand absorbs the wrap.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                     = 1'b1;
        grant[cand[IDX_W-1:0]] = 1'b1;
        idx                     = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fp_sign_sched.sv
// Shares one fp_sign datapath between NUM_REQ valid/ready requesters with
// round-robin arbitration and a single registered, backpressured output stage.
module fp_sign_sched
  import fp_sign_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int FLEN    = 64,
  parameter int TAG_W   = 5,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*FLEN-1:0]  req_op_a,
  input  logic [NUM_REQ*FLEN-1:0]  req_op_b,
  input  logic [NUM_REQ*2-1:0]     req_op,
  input  logic [NUM_REQ-1:0]       req_fmt,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FLEN-1:0]          out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic [IDX_W-1:0]         out_src
);

  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               accept;
  logic               fire;
  logic [FLEN-1:0]    sel_a;
  logic [FLEN-1:0]    sel_b;
  logic [1:0]         sel_op;
  logic               sel_fmt;
  logic [TAG_W-1:0]   sel_tag;
  logic [FLEN-1:0]    can_a;
  logic [FLEN-1:0]    can_b;
  logic [FLEN-1:0]    sign_result;
  logic [IDX_W-1:0]   next_ptr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Reset is folded in so req_ready drops the moment rst rises, not at the next edge.
  assign accept    = !rst && !flush && (!out_valid || out_ready);
  assign req_ready = accept ? grant : '0;
  assign fire      = accept && grant_any;

  assign sel_a   = req_op_a[grant_idx*FLEN +: FLEN];
  assign sel_b   = req_op_b[grant_idx*FLEN +: FLEN];
  assign sel_op  = req_op[grant_idx*2 +: 2];
  assign sel_fmt = req_fmt[grant_idx];
  assign sel_tag = req_tag[grant_idx*TAG_W +: TAG_W];

  // Only a 64-bit register file can hold an improperly boxed single.
  if (FLEN == 64) begin : g_nan_box
    assign can_a = nan_box_canon(sel_a, sel_fmt);
    assign can_b = nan_box_canon(sel_b, sel_fmt);
  end else begin : g_no_box
    assign can_a = sel_a;
    assign can_b = sel_b;
  end

  fp_sign #(
    .FLEN (FLEN)
  ) u_fp_sign (
    .op_a   (can_a),
    .op_b   (can_b),
    .op     (sel_op),
    .fmt    (sel_fmt),
    .result (sign_result)
  );

  assign next_ptr = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

  // Flush wins over everything; a new op may replace a result draining the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_src    <= '0;
      rr_ptr     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid  <= 1'b1;
      out_result <= sign_result;
      out_tag    <= sel_tag;
      out_src    <= grant_idx;
      rr_ptr     <= next_ptr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_sign_sched.sv
// Self-checking bench for fp_sign_sched: directed scenarios followed by random
// traffic, compared against a behavioural model of the scheduler.
module tb_fp_sign_sched;

  localparam int NUM_REQ = 2;
  localparam int FLEN    = 64;
  localparam int TAG_W   = 5;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     flush;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*FLEN-1:0]  req_op_a;
  logic [NUM_REQ*FLEN-1:0]  req_op_b;
  logic [NUM_REQ*2-1:0]     req_op;
  logic [NUM_REQ-1:0]       req_fmt;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic [FLEN-1:0]          out_result;
  logic [TAG_W-1:0]         out_tag;
  logic [0:0]               out_src;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        m_valid;
  logic [63:0] m_result;
  logic [4:0]  m_tag;
  int          m_src;
  int          m_ptr;

  fp_sign_sched #(
    .NUM_REQ (NUM_REQ),
    .FLEN    (FLEN),
    .TAG_W   (TAG_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op_a   (req_op_a),
    .req_op_b   (req_op_b),
    .req_op     (req_op),
    .req_fmt    (req_fmt),
    .req_tag    (req_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_src    (out_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Sign injection straight from the instruction definitions.
  function automatic logic [63:0] ref_sign(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] op, input logic fmt);
    logic [63:0] ca;
    logic [63:0] cb;
    logic        sa;
    logic        sb;
    logic        s;
    ca = a;
    cb = b;
    if (!fmt) begin
      if (a[63:32] !== 32'hFFFF_FFFF) ca = 64'hFFFF_FFFF_7FC0_0000;
      if (b[63:32] !== 32'hFFFF_FFFF) cb = 64'hFFFF_FFFF_7FC0_0000;
      sa = ca[31];
      sb = cb[31];
    end else begin
      sa = ca[63];
      sb = cb[63];
    end
    case (op)
      2'd0:    s = sb;
      2'd1:    s = !sb;
      2'd2:    s = sa ^ sb;
      default: s = sa;
    endcase
    if (fmt) ca[63] = s;
    else     ca[31] = s;
    return ca;
  endfunction

  function automatic int pick(input logic [NUM_REQ-1:0] valid, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (valid[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [63:0] rand_opnd(input logic fmt);
    logic [63:0] v;
    v = {$urandom, $urandom};
    if (!fmt && ($urandom_range(0, 3) != 0)) v[63:32] = 32'hFFFF_FFFF;
    return v;
  endfunction

  task automatic set_port(input int p, input logic v, input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] op, input logic fmt, input logic [4:0] tag);
    req_valid[p]               = v;
    req_op_a[p*FLEN +: FLEN]   = a;
    req_op_b[p*FLEN +: FLEN]   = b;
    req_op[p*2 +: 2]           = op;
    req_fmt[p]                 = fmt;
    req_tag[p*TAG_W +: TAG_W]  = tag;
  endtask

  task automatic apply_stimulus();
    for (int p = 0; p < NUM_REQ; p++) begin
      logic f;
      f = $urandom_range(0, 1);
      set_port(p, 1'($urandom_range(0, 1)), rand_opnd(f), rand_opnd(f),
               2'($urandom_range(0, 3)), f, 5'($urandom_range(0, 31)));
    end
    flush     = ($urandom_range(0, 15) == 0);
    out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Called at a falling edge with inputs already driven; ends at the next falling edge.
  task automatic check_output(input string name);
    int          g;
    logic [1:0]  exp_ready;
    logic        acc;
    #1;
    acc       = !flush && (!m_valid || out_ready);
    g         = acc ? pick(req_valid, m_ptr) : -1;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check({name, ".ready"}, 64'(req_ready), 64'(exp_ready));
    @(posedge clk);
    if (flush) begin
      m_valid = 1'b0;
    end else if (g >= 0) begin
      m_valid  = 1'b1;
      m_result = ref_sign(req_op_a[g*FLEN +: FLEN], req_op_b[g*FLEN +: FLEN],
                          req_op[g*2 +: 2], req_fmt[g]);
      m_tag    = req_tag[g*TAG_W +: TAG_W];
      m_src    = g;
      m_ptr    = (g + 1) % NUM_REQ;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check({name, ".valid"}, 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      check({name, ".result"}, out_result, m_result);
      check({name, ".tag"}, 64'(out_tag), 64'(m_tag));
      check({name, ".src"}, 64'(out_src), 64'(m_src));
    end
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    req_valid = '0;
    req_op_a  = '0;
    req_op_b  = '0;
    req_op    = '0;
    req_fmt   = '0;
    req_tag   = '0;
    m_valid   = 1'b0;
    m_result  = '0;
    m_tag     = '0;
    m_src     = 0;
    m_ptr     = 0;

    // Reset values, with requests pending that must not be accepted
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.result", out_result, 64'd0);
    check("rst.tag", 64'(out_tag), 64'd0);
    check("rst.src", 64'(out_src), 64'd0);
    check("rst.ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    req_valid = '0;
    rst       = 1'b0;

    $display("[TB] single op");
    set_port(0, 1'b1, 64'hFFFF_FFFF_3F80_0000, 64'hFFFF_FFFF_C000_0000, 2'b00, 1'b0, 5'd3);
    check_output("single");
    check("single.const", out_result, 64'hFFFF_FFFF_BF80_0000);
    check("single.srcconst", 64'(out_src), 64'd0);
    req_valid = '0;
    check_output("drain");

    $display("[TB] fairness");
    for (int i = 0; i < 6; i++) begin
      set_port(0, 1'b1, rand_opnd(1'b0), rand_opnd(1'b0), 2'($urandom_range(0, 3)), 1'b0, 5'(i));
      set_port(1, 1'b1, rand_opnd(1'b1), rand_opnd(1'b1), 2'($urandom_range(0, 3)), 1'b1, 5'(i + 16));
      check_output("fair");
    end

    $display("[TB] backpressure");
    out_ready = 1'b0;
    repeat (4) check_output("bp_hold");
    out_ready = 1'b1;
    repeat (2) check_output("bp_drain");

    $display("[TB] nan boxing");
    req_valid = '0;
    set_port(1, 1'b1, 64'h0000_0000_3F80_0000, 64'h0, 2'b01, 1'b0, 5'd7);
    check_output("box_s");
    check("box_s.const", out_result, 64'hFFFF_FFFF_FFC0_0000);
    set_port(1, 1'b1, 64'h3FF0_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b10, 1'b1, 5'd8);
    check_output("box_d");
    check("box_d.const", out_result, 64'hBFF0_0000_0000_0000);

    $display("[TB] flush");
    set_port(0, 1'b1, rand_opnd(1'b1), rand_opnd(1'b1), 2'b00, 1'b1, 5'd9);
    req_valid = 2'b11;
    flush     = 1'b1;
    check_output("flush");
    flush = 1'b0;
    check_output("post_flush");
    check("post_flush.src", 64'(out_src), 64'd0);

    $display("[TB] async reset");
    check_output("pre_rst");
    #3;
    rst = 1'b1;
    #1;
    check("arst.valid", 64'(out_valid), 64'd0);
    check("arst.ready", 64'(req_ready), 64'd0);
    check("arst.result", out_result, 64'd0);
    m_valid  = 1'b0;
    m_result = '0;
    m_tag    = '0;
    m_src    = 0;
    m_ptr    = 0;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b11;
    check_output("post_rst");
    check("post_rst.src", 64'(out_src), 64'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      apply_stimulus();
      check_output("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
